// File: rtl/alu_issue_ctrl_if.sv
// Handshake, operand and ALU bus shared by alu_issue_ctrl and its environment.
interface alu_issue_ctrl_if #(
  parameter int n = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  instr;
  logic [n-1:0] rs1_val;
  logic [n-1:0] rs2_val;
  logic [n-1:0] imm;
  logic [n-1:0] pc;
  logic [n-1:0] alu_a;
  logic [n-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [n-1:0] alu_result;
  logic         alu_zero;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] result;
  logic         zero;
  logic         illegal;
  logic         taken;

  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, imm, pc, alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, result, zero, illegal, taken
  );

  modport master (
    output in_valid, instr, rs1_val, rs2_val, imm, pc, alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, result, zero, illegal, taken
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes one RISC-V ALU instruction, drives an external combinational ALU
// and returns its result. Defining ALU_ISSUE_BRANCH_EN adds beq/bne decode and the taken flag.
module alu_issue_ctrl #(
  parameter int n = 32
) (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] SEL_AND   = 4'b0000;
  localparam logic [3:0] SEL_OR    = 4'b0001;
  localparam logic [3:0] SEL_ADD   = 4'b0010;
  localparam logic [3:0] SEL_AUIPC = 4'b0011;
  localparam logic [3:0] SEL_SUB   = 4'b0110;
  localparam logic [3:0] SEL_NOP   = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       legal;
    logic [3:0] sel;
    logic       a_pc;
    logic       b_imm;
    logic       branch;
    logic       bne;
  } dec_t;

  // R-type checks the whole funct7 so M-extension and shift encodings fall out as illegal.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d     = '0;
    d.sel = SEL_NOP;
    case (ins[6:0])
      OP_R: begin
        d.legal = 1'b1;
        case ({ins[31:25], ins[14:12]})
          {7'b0000000, 3'b000}: d.sel = SEL_ADD;
          {7'b0100000, 3'b000}: d.sel = SEL_SUB;
          {7'b0000000, 3'b111}: d.sel = SEL_AND;
          {7'b0000000, 3'b110}: d.sel = SEL_OR;
          default: begin
            d.legal = 1'b0;
            d.sel   = SEL_NOP;
          end
        endcase
      end
      OP_I: begin
        d.legal = 1'b1;
        d.b_imm = 1'b1;
        case (ins[14:12])
          3'b000:  d.sel = SEL_ADD;
          3'b111:  d.sel = SEL_AND;
          3'b110:  d.sel = SEL_OR;
          default: begin
            d.legal = 1'b0;
            d.sel   = SEL_NOP;
          end
        endcase
      end
      OP_AUIPC: begin
        d.legal = 1'b1;
        d.sel   = SEL_AUIPC;
        d.a_pc  = 1'b1;
        d.b_imm = 1'b1;
      end
`ifdef ALU_ISSUE_BRANCH_EN
      OP_BRANCH: begin
        d.legal  = 1'b1;
        d.branch = 1'b1;
        d.sel    = SEL_SUB;
        case (ins[14:12])
          3'b000:  d.bne = 1'b0;
          3'b001:  d.bne = 1'b1;
          default: begin
            d.legal  = 1'b0;
            d.branch = 1'b0;
            d.sel    = SEL_NOP;
          end
        endcase
      end
`endif
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t       r_state;
  state_t       w_next;
  dec_t         w_dec;
  logic         w_accept;
  logic         w_capture;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [n-1:0] r_alu_a;
  logic [n-1:0] r_alu_b;
  logic [3:0]   r_alu_sel;
  logic [n-1:0] r_result;
  logic         r_zero;
  logic         r_illegal;
  logic         w_unused;

  assign w_dec     = decode(bus.instr);
  assign w_accept  = bus.in_valid & r_in_ready & (r_state == IDLE);
  assign w_capture = (r_state == CAPTURE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_dec.legal ? ISSUE : DONE;
        end else begin
          w_next = IDLE;
        end
      end
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = DONE;
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake flags mirror the next state so they are registered yet track the FSM exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
    end
  end

  // Operands are held through CAPTURE so the ALU output is still valid when sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= SEL_NOP;
    end else begin
      case (w_next)
        ISSUE: begin
          r_alu_a   <= w_dec.a_pc  ? bus.pc  : bus.rs1_val;
          r_alu_b   <= w_dec.b_imm ? bus.imm : bus.rs2_val;
          r_alu_sel <= w_dec.sel;
        end
        CAPTURE: begin
          r_alu_a   <= r_alu_a;
          r_alu_b   <= r_alu_b;
          r_alu_sel <= r_alu_sel;
        end
        default: begin
          r_alu_a   <= '0;
          r_alu_b   <= '0;
          r_alu_sel <= SEL_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= ~w_dec.legal;
    end else if (w_capture) begin
      r_result  <= bus.alu_result;
      r_zero    <= bus.alu_zero;
      r_illegal <= 1'b0;
    end else begin
      r_result  <= r_result;
      r_zero    <= r_zero;
      r_illegal <= r_illegal;
    end
  end

`ifdef ALU_ISSUE_BRANCH_EN
  logic r_branch;
  logic r_bne;
  logic r_taken;

  // Branch kind is latched at acceptance; the outcome comes from the ALU zero flag in CAPTURE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch <= 1'b0;
      r_bne    <= 1'b0;
      r_taken  <= 1'b0;
    end else if (w_accept) begin
      r_branch <= w_dec.legal & w_dec.branch;
      r_bne    <= w_dec.bne;
      r_taken  <= 1'b0;
    end else if (w_capture) begin
      r_branch <= r_branch;
      r_bne    <= r_bne;
      r_taken  <= r_branch & (r_bne ? ~bus.alu_zero : bus.alu_zero);
    end else begin
      r_branch <= r_branch;
      r_bne    <= r_bne;
      r_taken  <= r_taken;
    end
  end

  assign bus.taken = r_taken;
  assign w_unused  = ^{bus.instr[24:15], bus.instr[11:7]};
`else
  assign bus.taken = 1'b0;
  assign w_unused  = ^{bus.instr[24:15], bus.instr[11:7], w_dec.branch, w_dec.bne};
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the operand bus.
module tb_alu_issue_ctrl;
  localparam int N = 32;

  localparam logic [31:0] I_ADD   = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] I_SUB   = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] I_AND   = {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011};
  localparam logic [31:0] I_OR    = {7'b0000000, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0110011};
  localparam logic [31:0] I_XOR   = {7'b0000000, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011};
  localparam logic [31:0] I_ADDI  = {12'd4, 5'd1, 3'b000, 5'd3, 7'b0010011};
  localparam logic [31:0] I_AUIPC = {20'h00001, 5'd3, 7'b0010111};
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_BEQ   = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] I_BNE   = {7'b0000000, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011};

  logic         clk = 1'b0;
  logic         rst;
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] alu_r;

  alu_issue_ctrl_if #(.n(N)) bus ();

  alu_issue_ctrl #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU answering the select codes the controller issues
  always_comb begin
    case (bus.alu_sel)
      4'b0000:          alu_r = bus.alu_a & bus.alu_b;
      4'b0001:          alu_r = bus.alu_a | bus.alu_b;
      4'b0010, 4'b0011: alu_r = bus.alu_a + bus.alu_b;
      4'b0110:          alu_r = bus.alu_a - bus.alu_b;
      default:          alu_r = '0;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == '0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] im, input logic [N-1:0] p);
    bus.instr    = ins;
    bus.rs1_val  = a;
    bus.rs2_val  = b;
    bus.imm      = im;
    bus.pc       = p;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", bus.in_ready); end
    total++; if ({bus.out_valid, bus.zero, bus.illegal, bus.taken} !== 4'b0000) begin bad++;
      $display("FAIL rst_flags got=%b want=0000", {bus.out_valid, bus.zero, bus.illegal, bus.taken}); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL rst_result got=%0h want=0", bus.result); end
    total++; if ({bus.alu_a, bus.alu_b} !== 64'd0) begin bad++; $display("FAIL rst_alu_ab got=%0h want=0", {bus.alu_a, bus.alu_b}); end
    total++; if (bus.alu_sel !== 4'b1111) begin bad++; $display("FAIL rst_alu_sel got=%b want=1111", bus.alu_sel); end
    rst = 1'b1;
    step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%0b want=1", bus.in_ready); end
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    issue(I_ADD, 32'd5, 32'd7, 32'd100, 32'd0);
    total++; if (bus.alu_sel !== 4'b0010) begin bad++; $display("FAIL add_sel got=%b want=0010", bus.alu_sel); end
    total++; if ({bus.alu_a, bus.alu_b} !== {32'd5, 32'd7}) begin bad++; $display("FAIL add_ops got=%0d,%0d want=5,7", bus.alu_a, bus.alu_b); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_ov_c1 got=%0b want=0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_ov_c2 got=%0b want=0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_ov_c3 got=%0b want=1", bus.out_valid); end
    total++; if (bus.result !== 32'd12) begin bad++; $display("FAIL add_result got=%0d want=12", bus.result); end
    total++; if ({bus.zero, bus.illegal, bus.in_ready} !== 3'b000) begin bad++;
      $display("FAIL add_flags got=%b want=000", {bus.zero, bus.illegal, bus.in_ready}); end
    total++; if (bus.alu_sel !== 4'b1111) begin bad++; $display("FAIL add_done_sel got=%b want=1111", bus.alu_sel); end
    step();
    total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++;
      $display("FAIL add_back_idle got=%b want=01", {bus.out_valid, bus.in_ready}); end
  endtask

  task automatic test_sub();
    issue(I_SUB, 32'd9, 32'd9, 32'd1, 32'd0);
    total++; if (bus.alu_sel !== 4'b0110) begin bad++; $display("FAIL sub_sel got=%b want=0110", bus.alu_sel); end
    step();
    step();
    total++; if ({bus.out_valid, bus.zero} !== 2'b11) begin bad++; $display("FAIL sub_valid_zero got=%b want=11", {bus.out_valid, bus.zero}); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL sub_result got=%0d want=0", bus.result); end
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] vec [2];
    vec[0] = I_ILL;
    vec[1] = I_XOR;
    for (int i = 0; i < 2; i++) begin
      issue(vec[i], 32'd3, 32'd4, 32'd5, 32'd6);
      total++; if ({bus.out_valid, bus.illegal, bus.in_ready} !== 3'b110) begin bad++;
        $display("FAIL ill%0d_flags got=%b want=110", i, {bus.out_valid, bus.illegal, bus.in_ready}); end
      total++; if ({bus.result, bus.zero, bus.taken} !== 34'd0) begin bad++;
        $display("FAIL ill%0d_result got=%0h want=0", i, {bus.result, bus.zero, bus.taken}); end
      total++; if (bus.alu_sel !== 4'b1111) begin bad++; $display("FAIL ill%0d_sel got=%b want=1111", i, bus.alu_sel); end
      step();
      total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++;
        $display("FAIL ill%0d_idle got=%b want=01", i, {bus.out_valid, bus.in_ready}); end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    issue(I_ADDI, 32'd3, 32'd99, 32'd4, 32'd0);
    total++; if ({bus.alu_sel, bus.alu_b} !== {4'b0010, 32'd4}) begin bad++;
      $display("FAIL addi_issue got=%b,%0d want=0010,4", bus.alu_sel, bus.alu_b); end
    step();
    step();
    // A competing instruction is offered throughout the stall and must not be taken.
    bus.instr    = I_ADD;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      total++; if ({bus.out_valid, bus.in_ready, bus.illegal} !== 3'b100 || bus.result !== 32'd7) begin bad++;
        $display("FAIL addi_hold%0d got=%b,%0d want=100,7", c, {bus.out_valid, bus.in_ready, bus.illegal}, bus.result); end
      if (c < 5) step();
    end
    bus.out_ready = 1'b1;
    step();
    total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++;
      $display("FAIL addi_release got=%b want=01", {bus.out_valid, bus.in_ready}); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(I_ADD, 32'd1, 32'd2, 32'd0, 32'd0);
    total++; if (bus.alu_sel !== 4'b0010) begin bad++; $display("FAIL mid_pre_sel got=%b want=0010", bus.alu_sel); end
    rst = 1'b0;
    #1;
    total++; if ({bus.in_ready, bus.out_valid} !== 2'b00) begin bad++;
      $display("FAIL mid_rst_flags got=%b want=00", {bus.in_ready, bus.out_valid}); end
    total++; if ({bus.alu_sel, bus.alu_a} !== {4'b1111, 32'd0}) begin bad++;
      $display("FAIL mid_rst_alu got=%b,%0d want=1111,0", bus.alu_sel, bus.alu_a); end
    step();
    rst = 1'b1;
    step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready got=%0b want=1", bus.in_ready); end
    for (int c = 0; c < 4; c++) begin
      total++; if (bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin bad++;
        $display("FAIL mid_stale%0d got=%0b,%0d want=0,0", c, bus.out_valid, bus.result); end
      step();
    end
  endtask

  task automatic test_logic();
    logic [31:0] ins [3];
    logic [31:0] exp_res [3];
    logic [3:0]  exp_sel [3];
    ins[0] = I_AND;   exp_sel[0] = 4'b0000; exp_res[0] = 32'h0000F000;
    ins[1] = I_OR;    exp_sel[1] = 4'b0001; exp_res[1] = 32'h0000FFF0;
    ins[2] = I_AUIPC; exp_sel[2] = 4'b0011; exp_res[2] = 32'h00001100;
    for (int i = 0; i < 3; i++) begin
      issue(ins[i], 32'h0000F0F0, 32'h0000FF00, 32'h00001000, 32'h00000100);
      total++; if (bus.alu_sel !== exp_sel[i]) begin bad++; $display("FAIL logic%0d_sel got=%b want=%b", i, bus.alu_sel, exp_sel[i]); end
      step();
      step();
      total++; if (bus.out_valid !== 1'b1 || bus.result !== exp_res[i]) begin bad++;
        $display("FAIL logic%0d_result got=%0b,%h want=1,%h", i, bus.out_valid, bus.result, exp_res[i]); end
      step();
    end
  endtask

  task automatic test_branch();
`ifdef ALU_ISSUE_BRANCH_EN
    issue(I_BEQ, 32'd20, 32'd20, 32'd8, 32'd0);
    total++; if (bus.alu_sel !== 4'b0110) begin bad++; $display("FAIL beq_sel got=%b want=0110", bus.alu_sel); end
    step();
    step();
    total++; if ({bus.out_valid, bus.taken, bus.zero, bus.illegal} !== 4'b1110) begin bad++;
      $display("FAIL beq_taken got=%b want=1110", {bus.out_valid, bus.taken, bus.zero, bus.illegal}); end
    step();
    issue(I_BNE, 32'd20, 32'd20, 32'd8, 32'd0);
    step();
    step();
    total++; if ({bus.out_valid, bus.taken, bus.zero} !== 3'b101) begin bad++;
      $display("FAIL bne_eq got=%b want=101", {bus.out_valid, bus.taken, bus.zero}); end
    step();
    issue(I_BNE, 32'd20, 32'd21, 32'd8, 32'd0);
    step();
    step();
    total++; if ({bus.out_valid, bus.taken, bus.zero} !== 3'b110) begin bad++;
      $display("FAIL bne_ne got=%b want=110", {bus.out_valid, bus.taken, bus.zero}); end
    step();
`else
    issue(I_BEQ, 32'd20, 32'd20, 32'd8, 32'd0);
    total++; if ({bus.out_valid, bus.illegal, bus.taken} !== 3'b110) begin bad++;
      $display("FAIL beq_disabled got=%b want=110", {bus.out_valid, bus.illegal, bus.taken}); end
    total++; if (bus.alu_sel !== 4'b1111) begin bad++; $display("FAIL beq_disabled_sel got=%b want=1111", bus.alu_sel); end
    step();
`endif
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.instr     = 32'd0;
    bus.rs1_val   = 32'd0;
    bus.rs2_val   = 32'd0;
    bus.imm       = 32'd0;
    bus.pc        = 32'd0;
    step();
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_logic();
    test_branch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
